// File: rtl/bp_dma_pkg.sv
// Shared types for the DMA sequencer: FSM state encoding and a width-parameterised
// descriptor struct (base, stride, count) supplied as a macro.
`ifndef BP_DMA_PKG_SV
`define BP_DMA_PKG_SV

`define BP_DMA_DESC_S(addr_w, stride_w, count_w) \
    struct packed { \
        logic [addr_w-1:0]   base; \
        logic [stride_w-1:0] stride; \
        logic [count_w-1:0]  count; \
    }

package bp_dma_pkg;

    typedef enum logic [1:0] {
        e_idle = 2'd0,
        e_run  = 2'd1,
        e_done = 2'd2
    } bp_dma_seq_state_e;

endpackage

`endif

// File: rtl/bp_dma_seq_buffer.sv
// 1r1w FIFO holding returned read data until the write side retires it.
// The head is read straight from storage flops, so a word is visible the cycle after enqueue.
module bp_dma_seq_buffer #(
    parameter int width_p = 64,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               enq_v_i,
    input  logic [width_p-1:0] enq_data_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int ptr_width_lp = $clog2(els_p);
    localparam logic [ptr_width_lp:0] ptr_one_lp = (ptr_width_lp + 1)'(1);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ptr_width_lp:0] wptr_q, rptr_q;
    logic [width_p-1:0]    mem_q [els_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (enq_v_i) begin
                mem_q[wptr_q[ptr_width_lp-1:0]] <= enq_data_i;
                wptr_q <= wptr_q + ptr_one_lp;
            end
            if (deq_i) begin
                rptr_q <= rptr_q + ptr_one_lp;
            end
        end
    end

    assign data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp])
                  && (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0]);

endmodule

// File: rtl/bp_dma_seq_engine.sv
// Strided copy sequencer: issues credit-limited reads, buffers the data in order and
// writes each word to the strided destination, reporting busy/done/err to the CSRs.
module bp_dma_seq_engine
    import bp_dma_pkg::*;
#(
    parameter int addr_width_p   = 32,
    parameter int data_width_p   = 64,
    parameter int stride_width_p = 32,
    parameter int count_width_p  = 32,
    parameter int buf_els_p      = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [addr_width_p-1:0]   rd_base_addr_i,
    input  logic [stride_width_p-1:0] rd_stride_i,
    input  logic [count_width_p-1:0]  rd_count_i,
    input  logic [addr_width_p-1:0]   wr_base_addr_i,
    input  logic [stride_width_p-1:0] wr_stride_i,
    input  logic [count_width_p-1:0]  wr_count_i,
    output logic [addr_width_p-1:0]   rd_req_addr_o,
    output logic                      rd_req_v_o,
    input  logic                      rd_req_ready_and_i,
    input  logic [data_width_p-1:0]   rd_resp_data_i,
    input  logic                      rd_resp_v_i,
    output logic                      rd_resp_ready_and_o,
    output logic [addr_width_p-1:0]   wr_req_addr_o,
    output logic [data_width_p-1:0]   wr_req_data_o,
    output logic                      wr_req_v_o,
    input  logic                      wr_req_ready_and_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int credit_width_lp = $clog2(buf_els_p) + 1;
    localparam logic [credit_width_lp-1:0] credit_one_lp = credit_width_lp'(1);
    localparam logic [count_width_p-1:0]   count_one_lp  = count_width_p'(1);

    typedef `BP_DMA_DESC_S(addr_width_p, stride_width_p, count_width_p) desc_s;

    // Latched descriptors double as cursors: base advances and count falls as words move.
    bp_dma_seq_state_e          state_q, state_d;
    desc_s                      rd_q, rd_d, wr_q, wr_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic                       err_q, err_d;

    logic                       rd_hs, wr_hs, resp_hs;
    logic                       buf_empty, buf_full;
    logic [data_width_p-1:0]    buf_data;

    assign rd_req_v_o          = (state_q == e_run) && (rd_q.count != '0) && (credits_q != '0);
    assign rd_req_addr_o       = rd_q.base;
    assign rd_resp_ready_and_o = (state_q == e_run);
    assign wr_req_v_o          = !buf_empty;
    assign wr_req_addr_o       = wr_q.base;
    assign wr_req_data_o       = buf_data;
    assign busy_o              = (state_q != e_idle);
    assign done_o              = (state_q == e_done);
    assign err_o               = err_q;

    assign rd_hs   = rd_req_v_o && rd_req_ready_and_i;
    assign wr_hs   = wr_req_v_o && wr_req_ready_and_i;
    assign resp_hs = rd_resp_v_i && rd_resp_ready_and_o;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        credits_d = credits_q;
        err_d     = err_q;
        unique case (state_q)
            e_idle: begin
                if (start_i) begin
                    if (rd_count_i != wr_count_i) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (rd_count_i == '0) begin
                            state_d = e_done;
                        end else begin
                            rd_d.base   = rd_base_addr_i;
                            rd_d.stride = rd_stride_i;
                            rd_d.count  = rd_count_i;
                            wr_d.base   = wr_base_addr_i;
                            wr_d.stride = wr_stride_i;
                            wr_d.count  = wr_count_i;
                            credits_d   = credit_width_lp'(buf_els_p);
                            state_d     = e_run;
                        end
                    end
                end
            end
            e_run: begin
                if (rd_hs) begin
                    rd_d.base  = rd_q.base + addr_width_p'(rd_q.stride);
                    rd_d.count = rd_q.count - count_one_lp;
                end
                if (wr_hs) begin
                    wr_d.base  = wr_q.base + addr_width_p'(wr_q.stride);
                    wr_d.count = wr_q.count - count_one_lp;
                    if (wr_q.count == count_one_lp) begin
                        state_d = e_done;
                    end
                end
                // A read issued and a write retired in the same cycle cancel out.
                if (rd_hs && !wr_hs) begin
                    credits_d = credits_q - credit_one_lp;
                end else if (wr_hs && !rd_hs) begin
                    credits_d = credits_q + credit_one_lp;
                end
            end
            e_done: begin
                state_d = e_idle;
            end
            default: begin
                state_d = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            rd_q      <= '0;
            wr_q      <= '0;
            credits_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    bp_dma_seq_buffer #(
        .width_p (data_width_p),
        .els_p   (buf_els_p)
    ) u_buf (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_v_i    (resp_hs),
        .enq_data_i (rd_resp_data_i),
        .deq_i      (wr_hs),
        .data_o     (buf_data),
        .empty_o    (buf_empty),
        .full_o     (buf_full)
    );

    // Credits bound outstanding reads to the buffer depth, so a full buffer never sees an enqueue.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(resp_hs && buf_full));
        end
    end

endmodule

// File: tb/tb_bp_dma_seq_engine.sv
// Directed-plus-random bench for bp_dma_seq_engine with a memory/bus model and
// a per-index address/data reference computed from base + i*stride.
module tb_bp_dma_seq_engine;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = 32;
    localparam int CW = 32;
    localparam int BE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n_i          = 1'b0;
    logic          start_i            = 1'b0;
    logic [AW-1:0] rd_base_addr_i     = '0;
    logic [SW-1:0] rd_stride_i        = '0;
    logic [CW-1:0] rd_count_i         = '0;
    logic [AW-1:0] wr_base_addr_i     = '0;
    logic [SW-1:0] wr_stride_i        = '0;
    logic [CW-1:0] wr_count_i         = '0;
    logic          rd_req_ready_and_i = 1'b0;
    logic [DW-1:0] rd_resp_data_i     = '0;
    logic          rd_resp_v_i        = 1'b0;
    logic          wr_req_ready_and_i = 1'b0;
    logic [AW-1:0] rd_req_addr_o;
    logic          rd_req_v_o;
    logic          rd_resp_ready_and_o;
    logic [AW-1:0] wr_req_addr_o;
    logic [DW-1:0] wr_req_data_o;
    logic          wr_req_v_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    bp_dma_seq_engine #(
        .addr_width_p   (AW),
        .data_width_p   (DW),
        .stride_width_p (SW),
        .count_width_p  (CW),
        .buf_els_p      (BE)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n_i),
        .start_i             (start_i),
        .rd_base_addr_i      (rd_base_addr_i),
        .rd_stride_i         (rd_stride_i),
        .rd_count_i          (rd_count_i),
        .wr_base_addr_i      (wr_base_addr_i),
        .wr_stride_i         (wr_stride_i),
        .wr_count_i          (wr_count_i),
        .rd_req_addr_o       (rd_req_addr_o),
        .rd_req_v_o          (rd_req_v_o),
        .rd_req_ready_and_i  (rd_req_ready_and_i),
        .rd_resp_data_i      (rd_resp_data_i),
        .rd_resp_v_i         (rd_resp_v_i),
        .rd_resp_ready_and_o (rd_resp_ready_and_o),
        .wr_req_addr_o       (wr_req_addr_o),
        .wr_req_data_o       (wr_req_data_o),
        .wr_req_v_o          (wr_req_v_o),
        .wr_req_ready_and_i  (wr_req_ready_and_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o)
    );

    int compared   = 0;
    int mismatched = 0;

    // Observed traffic and the data the memory model handed back, in order.
    logic [AW-1:0] rd_obs_q[$];
    logic [AW-1:0] wr_addr_obs_q[$];
    logic [DW-1:0] wr_data_obs_q[$];
    logic [DW-1:0] gen_q[$];
    logic [DW-1:0] pend_data_q[$];
    int            pend_due_q[$];
    logic [AW-1:0] exp_q[$];
    logic [DW-1:0] exp_data_q[$];

    int   tick        = 0;
    int   lat         = 1;
    int   rd_rdy_mode = 0;  // 0: always ready, 1: random
    int   wr_rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled
    int   done_cnt    = 0;
    int   resp_cnt    = 0;
    int   ovf_cnt     = 0;
    bit   bus_flush   = 1'b0;
    logic [DW-1:0] bus_d;

    // Memory/bus model: runs mid-cycle, decides this cycle's inputs and logs the
    // handshakes that the coming rising edge will complete.
    always @(posedge clk) begin
        #2;
        tick++;
        if (bus_flush) begin
            pend_data_q.delete();
            pend_due_q.delete();
        end
        if (pend_data_q.size() > 0 && pend_due_q[0] <= tick
            && (rd_rdy_mode == 0 || $urandom_range(0, 3) != 0)) begin
            rd_resp_v_i    = 1'b1;
            rd_resp_data_i = pend_data_q[0];
            if (rd_resp_ready_and_o) begin
                if (dut.u_buf.full_o) ovf_cnt++;
                void'(pend_data_q.pop_front());
                void'(pend_due_q.pop_front());
                resp_cnt++;
            end
        end else begin
            rd_resp_v_i    = 1'b0;
            rd_resp_data_i = '0;
        end
        rd_req_ready_and_i = (rd_rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (rd_req_v_o && rd_req_ready_and_i) begin
            rd_obs_q.push_back(rd_req_addr_o);
            bus_d = {$urandom, $urandom};
            gen_q.push_back(bus_d);
            pend_data_q.push_back(bus_d);
            pend_due_q.push_back(tick + lat);
        end
        case (wr_rdy_mode)
            0:       wr_req_ready_and_i = 1'b1;
            1:       wr_req_ready_and_i = 1'($urandom_range(0, 1));
            default: wr_req_ready_and_i = 1'b0;
        endcase
        if (wr_req_v_o && wr_req_ready_and_i) begin
            wr_addr_obs_q.push_back(wr_req_addr_o);
            wr_data_obs_q.push_back(wr_req_data_o);
        end
        if (done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        rd_obs_q.delete();
        wr_addr_obs_q.delete();
        wr_data_obs_q.delete();
        gen_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] rb, input logic [SW-1:0] rs,
                               input logic [CW-1:0] rc, input logic [AW-1:0] wb,
                               input logic [SW-1:0] ws, input logic [CW-1:0] wc);
        @(negedge clk);
        rd_base_addr_i = rb;
        rd_stride_i    = rs;
        rd_count_i     = rc;
        wr_base_addr_i = wb;
        wr_stride_i    = ws;
        wr_count_i     = wc;
        start_i        = 1'b1;
        @(negedge clk);
        start_i        = 1'b0;
    endtask

    task automatic start_xfer(input string name, input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                              input logic [SW-1:0] rs, input logic [SW-1:0] ws, input int cnt);
        clear_obs();
        pulse_start(rb, rs, CW'(cnt), wb, ws, CW'(cnt));
        chk({name, ":busy_n1"}, 64'(busy_o), 64'd1);
        chk({name, ":rd_v_n1"}, 64'(rd_req_v_o), 64'd1);
        chk({name, ":err_clear"}, 64'(err_o), 64'd0);
    endtask

    task automatic finish_xfer(input string name, input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                               input logic [SW-1:0] rs, input logic [SW-1:0] ws, input int cnt);
        int n = 0;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        while (done_o !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({name, ":done_seen"}, 64'(done_o), 64'd1);
        chk({name, ":busy_at_done"}, 64'(busy_o), 64'd1);
        @(negedge clk);
        chk({name, ":done_one_cycle"}, 64'(done_o), 64'd0);
        chk({name, ":busy_after"}, 64'(busy_o), 64'd0);
        chk({name, ":done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, ":n_reads"}, 64'(rd_obs_q.size()), 64'(cnt));
        chk({name, ":n_writes"}, 64'(wr_addr_obs_q.size()), 64'(cnt));
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(rb + AW'(i) * AW'(rs));
        end
        for (int i = 0; i < cnt; i++) begin
            oa = (rd_obs_q.size() > 0) ? rd_obs_q.pop_front() : 'x;
            chk($sformatf("%s:rd_addr[%0d]", name, i), 64'(oa), 64'(exp_q.pop_front()));
        end
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(wb + AW'(i) * AW'(ws));
            exp_data_q.push_back((gen_q.size() > i) ? gen_q[i] : 'x);
        end
        for (int i = 0; i < cnt; i++) begin
            oa = (wr_addr_obs_q.size() > 0) ? wr_addr_obs_q.pop_front() : 'x;
            od = (wr_data_obs_q.size() > 0) ? wr_data_obs_q.pop_front() : 'x;
            chk($sformatf("%s:wr_addr[%0d]", name, i), 64'(oa), 64'(exp_q.pop_front()));
            chk($sformatf("%s:wr_data[%0d]", name, i), od, exp_data_q.pop_front());
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ":rd_req_v"}, 64'(rd_req_v_o), 64'd0);
        chk({name, ":rd_req_addr"}, 64'(rd_req_addr_o), 64'd0);
        chk({name, ":rd_resp_rdy"}, 64'(rd_resp_ready_and_o), 64'd0);
        chk({name, ":wr_req_v"}, 64'(wr_req_v_o), 64'd0);
        chk({name, ":wr_req_addr"}, 64'(wr_req_addr_o), 64'd0);
        chk({name, ":wr_req_data"}, wr_req_data_o, 64'd0);
        chk({name, ":busy"}, 64'(busy_o), 64'd0);
        chk({name, ":done"}, 64'(done_o), 64'd0);
        chk({name, ":err"}, 64'(err_o), 64'd0);
    endtask

    initial begin
        int n;
        int resp_before;
        logic [AW-1:0] rb, wb;
        logic [SW-1:0] rs, ws;
        int cnt;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n_i = 1'b1;

        // Basic copy
        start_xfer("basic", 32'h1000, 32'h2000, 8, 8, 4);
        finish_xfer("basic", 32'h1000, 32'h2000, 8, 8, 4);

        // Zero count
        clear_obs();
        pulse_start(32'h1000, 8, 0, 32'h2000, 8, 0);
        chk("zero:done_n1", 64'(done_o), 64'd1);
        chk("zero:busy_n1", 64'(busy_o), 64'd1);
        chk("zero:rd_v_n1", 64'(rd_req_v_o), 64'd0);
        @(negedge clk);
        chk("zero:busy_n2", 64'(busy_o), 64'd0);
        chk("zero:done_n2", 64'(done_o), 64'd0);
        repeat (3) @(negedge clk);
        chk("zero:n_reads", 64'(rd_obs_q.size()), 64'd0);
        chk("zero:n_writes", 64'(wr_addr_obs_q.size()), 64'd0);

        // Count mismatch, then a valid start clears the error
        clear_obs();
        pulse_start(32'h1000, 8, 3, 32'h2000, 8, 2);
        chk("mism:err_n1", 64'(err_o), 64'd1);
        chk("mism:busy_n1", 64'(busy_o), 64'd0);
        repeat (4) @(negedge clk);
        chk("mism:err_sticky", 64'(err_o), 64'd1);
        chk("mism:busy_later", 64'(busy_o), 64'd0);
        chk("mism:n_reads", 64'(rd_obs_q.size()), 64'd0);
        start_xfer("after_mism", 32'h0100, 32'h0800, 4, 4, 2);
        finish_xfer("after_mism", 32'h0100, 32'h0800, 4, 4, 2);

        // Credit limit with writes stalled; a start during the run is ignored
        wr_rdy_mode = 2;
        start_xfer("credit", 32'h3000, 32'h6000, 4, 12, 10);
        repeat (20) @(negedge clk);
        chk("credit:n_reads_stalled", 64'(rd_obs_q.size()), 64'(BE));
        chk("credit:rd_v_dropped", 64'(rd_req_v_o), 64'd0);
        chk("credit:wr_v_held", 64'(wr_req_v_o), 64'd1);
        pulse_start(32'h0, 4, 1, 32'h0, 4, 2);
        chk("credit:start_ignored_err", 64'(err_o), 64'd0);
        chk("credit:start_ignored_busy", 64'(busy_o), 64'd1);
        wr_rdy_mode = 0;
        finish_xfer("credit", 32'h3000, 32'h6000, 4, 12, 10);

        // Address wraparound
        start_xfer("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFF0, 8, 16, 3);
        finish_xfer("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFF0, 8, 16, 3);

        // Randomized transfers with random ready patterns and latency
        for (int t = 0; t < 6; t++) begin
            rb  = $urandom;
            wb  = $urandom;
            rs  = (t[0]) ? SW'($urandom) : SW'($urandom_range(0, 64));
            ws  = (t[1]) ? SW'($urandom) : SW'($urandom_range(0, 64));
            cnt = $urandom_range(1, 12);
            lat = $urandom_range(1, 3);
            rd_rdy_mode = 1;
            wr_rdy_mode = 1;
            start_xfer($sformatf("rand%0d", t), rb, wb, rs, ws, cnt);
            finish_xfer($sformatf("rand%0d", t), rb, wb, rs, ws, cnt);
        end

        // Reset mid-run
        rd_rdy_mode = 0;
        wr_rdy_mode = 1;
        lat = 2;
        start_xfer("rst", 32'h4000, 32'h5000, 16, 16, 8);
        n = 0;
        while (wr_addr_obs_q.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst:two_writes_seen", 64'(wr_addr_obs_q.size() >= 2), 64'd1);
        reset_n_i = 1'b0;
        #1;
        chk_all_zero("rst_async");
        resp_before = resp_cnt;
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst:no_resp_accepted", 64'(resp_cnt), 64'(resp_before));
        chk("rst:resp_rdy_low", 64'(rd_resp_ready_and_o), 64'd0);
        chk("rst:no_done", 64'(done_cnt), 64'd0);
        chk("rst:idle", 64'(busy_o), 64'd0);
        bus_flush = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_flush = 1'b0;
        lat = 1;
        wr_rdy_mode = 0;
        start_xfer("post_rst", 32'h1000, 32'h2000, 8, 8, 4);
        finish_xfer("post_rst", 32'h1000, 32'h2000, 8, 8, 4);

        chk("no_buffer_overflow", 64'(ovf_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bp_dma_seq_engine.md
# bp_dma_seq_engine

Strided copy sequencer directly downstream of the DMA engine's TDMA CSR bank. It latches the rank-1 read and write descriptors (base, stride, count) on a start pulse. It then issues a stream of read requests, buffers the returned words in a credit-limited buffer, and issues one write request per word to the strided write address. It reports busy, done and a descriptor error back to the CSR/status path.

## Interface
Parameters:
- addr_width_p, 32: request address width; all address arithmetic is modulo 2^addr_width_p.
- data_width_p, 64: transfer word width.
- stride_width_p, 32: stride width; unsigned byte stride, zero-extended to the address width.
- count_width_p, 32: word-count width.
- buf_els_p, 4: data buffer depth, which is also the outstanding-read credit limit (power of 2, ≥2).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; **one clock; reset is asynchronous and active-low**.
- start_i  in  1  single-cycle start pulse from the CSR bank.
- rd_base_addr_i  in  addr_width_p  read base address.
- rd_stride_i  in  stride_width_p  read stride.
- rd_count_i  in  count_width_p  read word count.
- wr_base_addr_i  in  addr_width_p  write base address.
- wr_stride_i  in  stride_width_p  write stride.
- wr_count_i  in  count_width_p  write word count.
- rd_req_addr_o  out  addr_width_p  read request address.
- rd_req_v_o  out  1  read request valid.
- rd_req_ready_and_i  in  1  read request ready.
- rd_resp_data_i  in  data_width_p  read response data; responses arrive in order.
- rd_resp_v_i  in  1  read response valid.
- rd_resp_ready_and_o  out  1  read response ready.
- wr_req_addr_o  out  addr_width_p  write request address.
- wr_req_data_o  out  data_width_p  write request data.
- wr_req_v_o  out  1  write request valid.
- wr_req_ready_and_i  in  1  write request ready.
- busy_o  out  1  a transfer is in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky descriptor error; cleared by the next accepted start.

## Operation
- States: e_idle, e_run, e_done.
- e_idle with start_i:
  - If rd_count_i ≠ wr_count_i: set err_o and stay in e_idle.
  - Else if the count is 0: clear err_o and go to e_done.
  - Else: clear err_o, latch both descriptors, load rd_addr_r = rd_base, wr_addr_r = wr_base, rd_left_r = wr_left_r = count, credits_r = buf_els_p; go to e_run.
- start_i outside e_idle is ignored and does not change err_o.
- e_run, read side:
  - rd_req_v_o = (rd_left_r ≠ 0) && (credits_r ≠ 0).
  - On each rd_req handshake: rd_addr_r += stride, rd_left_r decrements, credits_r decrements.
- Responses:
  - rd_resp_ready_and_o = 1 in e_run, 0 otherwise.
  - Each accepted response is enqueued into the buffer. Credits guarantee the buffer has space.
- e_run, write side:
  - wr_req_v_o = buffer not empty; wr_req_data_o = buffer head.
  - On each wr_req handshake: dequeue, wr_addr_r += stride, wr_left_r decrements, credits_r increments.
- Simultaneous read issue and write retire in one cycle: credits_r is unchanged (net 0).
- When wr_left_r reaches 0 on a handshake, go to e_done.
- e_done: done_o = 1 for exactly one cycle, then return to e_idle.
- busy_o = (state ≠ e_idle).
- Address wrap past 2^addr_width_p−1 is silent modulo arithmetic and is not an error.

## Timing
- Reset values: all outputs 0, state e_idle, counters and buffer cleared.
- Reset asserted mid-run aborts immediately:
  - No done_o pulse.
  - Buffered data is discarded.
  - Outstanding responses arriving after reset are not accepted.
- Latency:
  - start_i at cycle N → busy_o and the first rd_req_v_o at N+1.
  - Response accepted at cycle M → wr_req_v_o at M+1 (registered buffer, no bypass).
  - Last write handshake at cycle K → done_o at K+1, busy_o low at K+2.
  - Zero count: done_o at N+1.
  - Count mismatch: err_o at N+1, busy_o stays 0.
- Handshakes are valid/ready_and. Once asserted, valid, address and data stay stable until the handshake completes.
- Throughput: one read and one write per cycle when both ready_and inputs are high and buf_els_p covers the response latency.

## Structure
- Shared package bp_dma_pkg holds:
  - the state enum bp_dma_seq_state_e;
  - the descriptor struct macro (base, stride, count), parameterised by widths.
- Sub-module bp_dma_seq_buffer: 1r1w FIFO of buf_els_p × data_width_p, asynchronous active-low reset, registered output, with full/empty flags.
- The full flag drives an assertion only. Enqueue while full is a protocol error, and the bench checks it never happens.

## Test plan
- Basic copy: count=4, rd_base=0x1000, wr_base=0x2000, strides 8, ready_and tied 1, 1-cycle response latency → reads to 0x1000/08/10/18, writes to 0x2000/08/10/18 with matching data in order, one done_o pulse.
- Zero count: start with count=0 → done_o at N+1, no requests issued, busy_o high one cycle only.
- Count mismatch: rd_count=3, wr_count=2 → err_o=1, busy_o stays 0, no requests. A following valid start clears err_o.
- Credit limit: buf_els_p=4, count=10, wr_req_ready_and_i held 0 for 20 cycles → exactly 4 reads issued, rd_req_v_o drops, traffic resumes when writes are released, 10 writes total.
- Wraparound: rd_base=0xFFFF_FFF8, stride 8, count 3 → read addresses 0xFFFF_FFF8, 0x0, 0x8.
- Reset mid-run: reset_n_i pulsed after 2 of 8 writes → all outputs 0 immediately, no done_o, a fresh start works normally.
